// File: rtl/rf_port_sched_pkg.sv
// rf_port_sched_pkg: register-file geometry, request types and range helper.
package rf_port_sched_pkg;
    localparam int phit_size    = 16;
    localparam int dwidth_RFadd = 4;
    localparam int depth_RF     = 12;
    localparam int NUM_REQ_DFLT = 4;
    localparam int REQ_IDX_W    = (NUM_REQ_DFLT > 1) ? $clog2(NUM_REQ_DFLT) : 1;

    typedef logic [REQ_IDX_W-1:0]    req_idx_t;
    typedef logic [dwidth_RFadd-1:0] rf_addr_t;
    typedef logic [phit_size-1:0]    phit_t;

    typedef struct packed {
        rf_addr_t addr1;
        rf_addr_t addr2;
    } rf_rd_req_t;

    function automatic logic addr_ok(input rf_addr_t a);
        return int'(a) < depth_RF;
    endfunction
endpackage

// File: rtl/rf_port_sched_rr_arbiter.sv
// rf_port_sched_rr_arbiter: one-hot round-robin arbiter, pointer moves past each winner.
module rf_port_sched_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] gnt_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d, idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr_q) + i) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = adv_i ? IW'((int'(idx) + 1) % N) : ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/rf_port_sched.sv
// rf_port_sched: round-robin read/write scheduler for the shared 2R/1W register file,
// with write-to-read bypass and sticky out-of-range detection.
module rf_port_sched
    import rf_port_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              rd_req_valid,
    input  logic [NUM_REQ*dwidth_RFadd-1:0] rd_req_addr1,
    input  logic [NUM_REQ*dwidth_RFadd-1:0] rd_req_addr2,
    output logic [NUM_REQ-1:0]              rd_req_ready,
    output logic [NUM_REQ-1:0]              rd_rsp_valid,
    output logic [phit_size-1:0]            rd_rsp_data1,
    output logic [phit_size-1:0]            rd_rsp_data2,
    input  logic [NUM_REQ-1:0]              wr_req_valid,
    input  logic [NUM_REQ*dwidth_RFadd-1:0] wr_req_addr,
    input  logic [NUM_REQ*phit_size-1:0]    wr_req_data,
    output logic [NUM_REQ-1:0]              wr_req_ready,
    output logic [dwidth_RFadd-1:0]         rf_rd_addr1,
    output logic [dwidth_RFadd-1:0]         rf_rd_addr2,
    output logic [dwidth_RFadd-1:0]         rf_wr_addr,
    output logic                            rf_wen,
    output logic [phit_size-1:0]            rf_d_in,
    input  logic [phit_size-1:0]            rf_d_out1,
    input  logic [phit_size-1:0]            rf_d_out2,
    output logic                            oob_err
);
    logic [NUM_REQ-1:0] rd_gnt, wr_gnt, rsp_valid_q, rsp_valid_d;
    rf_rd_req_t         rd_sel;
    rf_addr_t           wr_addr;
    phit_t              wr_data, op1, op2, d1_q, d1_d, d2_q, d2_d;
    logic               wr_hit, oob_q, oob_d;

    // Requests are masked during reset so nothing is granted or written.
    rf_port_sched_rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk(clk), .rst_n(rst_n), .req_i(rd_req_valid & {NUM_REQ{rst_n}}),
        .adv_i(1'b1), .gnt_o(rd_gnt)
    );

    rf_port_sched_rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk(clk), .rst_n(rst_n), .req_i(wr_req_valid & {NUM_REQ{rst_n}}),
        .adv_i(1'b1), .gnt_o(wr_gnt)
    );

    always_comb begin
        rd_sel  = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_gnt[i]) begin
                rd_sel.addr1 = rd_req_addr1[i*dwidth_RFadd +: dwidth_RFadd];
                rd_sel.addr2 = rd_req_addr2[i*dwidth_RFadd +: dwidth_RFadd];
            end
            if (wr_gnt[i]) begin
                wr_addr = wr_req_addr[i*dwidth_RFadd +: dwidth_RFadd];
                wr_data = wr_req_data[i*phit_size +: phit_size];
            end
        end
        wr_hit = (|wr_gnt) && addr_ok(wr_addr);
        op1 = !addr_ok(rd_sel.addr1) ? '0 :
              (wr_hit && wr_addr == rd_sel.addr1) ? wr_data : rf_d_out1;
        op2 = !addr_ok(rd_sel.addr2) ? '0 :
              (wr_hit && wr_addr == rd_sel.addr2) ? wr_data : rf_d_out2;
        rsp_valid_d = rd_gnt;
        d1_d  = (|rd_gnt) ? op1 : d1_q;
        d2_d  = (|rd_gnt) ? op2 : d2_q;
        oob_d = oob_q
              | ((|rd_gnt) && !(addr_ok(rd_sel.addr1) && addr_ok(rd_sel.addr2)))
              | ((|wr_gnt) && !addr_ok(wr_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            oob_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            oob_q       <= oob_d;
        end
    end

    assign rd_req_ready = rd_gnt;
    assign wr_req_ready = wr_gnt;
    assign rf_rd_addr1  = rd_sel.addr1;
    assign rf_rd_addr2  = rd_sel.addr2;
    assign rf_wr_addr   = wr_addr;
    assign rf_d_in      = wr_data;
    assign rf_wen       = wr_hit;
    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data1 = d1_q;
    assign rd_rsp_data2 = d2_q;
    assign oob_err      = oob_q;
endmodule

// File: tb/tb_rf_port_sched.sv
// tb_rf_port_sched: directed bench with a behavioural register file behind the scheduler.
module tb_rf_port_sched;
    import rf_port_sched_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  rd_v = '0, wr_v = '0;
    logic [15:0] rd_a1 = '0, rd_a2 = '0, wr_a = '0;
    logic [63:0] wr_d = '0;
    logic [3:0]  rd_rdy, wr_rdy, rsp_v;
    logic [15:0] d1, d2, rf_din, rf_do1, rf_do2;
    logic [3:0]  rf_ra1, rf_ra2, rf_wa;
    logic        rf_wen, oob;
    logic [15:0] mem [16];
    int          n_chk = 0, n_fail = 0;
    int          cnt [4];

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_wen) mem[rf_wa] <= rf_din;
    assign rf_do1 = (int'(rf_ra1) < depth_RF) ? mem[rf_ra1] : 16'hEEEE;
    assign rf_do2 = (int'(rf_ra2) < depth_RF) ? mem[rf_ra2] : 16'hEEEE;

    rf_port_sched #(.NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_v), .rd_req_addr1(rd_a1), .rd_req_addr2(rd_a2),
        .rd_req_ready(rd_rdy), .rd_rsp_valid(rsp_v),
        .rd_rsp_data1(d1), .rd_rsp_data2(d2),
        .wr_req_valid(wr_v), .wr_req_addr(wr_a), .wr_req_data(wr_d),
        .wr_req_ready(wr_rdy),
        .rf_rd_addr1(rf_ra1), .rf_rd_addr2(rf_ra2), .rf_wr_addr(rf_wa),
        .rf_wen(rf_wen), .rf_d_in(rf_din),
        .rf_d_out1(rf_do1), .rf_d_out2(rf_do2),
        .oob_err(oob)
    );

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] a1, a2;
        logic [3:0]  wv;
        logic [15:0] wa;
        logic [63:0] wd;
        logic [3:0]  e_rrdy, e_wrdy;
        logic        e_wen;
        logic [15:0] e_d1, e_d2;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic [3:0] rv, input logic [15:0] a1, a2,
                                input logic [3:0] wv, input logic [15:0] wa,
                                input logic [63:0] wd, input logic [3:0] er, ew,
                                input logic en, input logic [15:0] e1, e2);
        vec_t v;
        v.rv = rv; v.a1 = a1; v.a2 = a2; v.wv = wv; v.wa = wa; v.wd = wd;
        v.e_rrdy = er; v.e_wrdy = ew; v.e_wen = en; v.e_d1 = e1; v.e_d2 = e2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rd_v = '0;
        wr_v = '0;
    endtask

    task automatic set_rd(input int r, input logic [3:0] a1, input logic [3:0] a2);
        rd_v[r] = 1'b1;
        rd_a1[r*4 +: 4] = a1;
        rd_a2[r*4 +: 4] = a2;
    endtask

    task automatic set_wr(input int r, input logic [3:0] a, input logic [15:0] d);
        wr_v[r] = 1'b1;
        wr_a[r*4 +: 4] = a;
        wr_d[r*16 +: 16] = d;
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        idle();
        set_wr(3, a, d);
        #1;
        chk("preload wr_rdy", 64'(wr_rdy), 64'h8);
        chk("preload wen", 64'(rf_wen), 64'h1);
        tick();
    endtask

    initial begin
        // Row 0 moves the read pointer back to 0; rows 1-8 are the full-contention sweep.
        tbl[0]  = mk(4'b1000, 16'h6000, 16'h3000, 4'b0000, 16'h0, 64'h0, 4'b1000, 4'b0000, 1'b0, 16'h0077, 16'h00A5);
        for (int k = 0; k < 8; k++) begin
            logic [15:0] e1, e2;
            case (k % 4)
                0:       begin e1 = 16'h00A5; e2 = 16'h005A; end
                1:       begin e1 = 16'h005A; e2 = 16'h00A5; end
                2:       begin e1 = 16'h0077; e2 = 16'h00A5; end
                default: begin e1 = 16'h005A; e2 = 16'h0077; end
            endcase
            tbl[k+1] = mk(4'b1111, 16'h7673, 16'h6337, 4'b0000, 16'h0, 64'h0,
                          4'(1 << (k % 4)), 4'b0000, 1'b0, e1, e2);
        end
        tbl[9]  = mk(4'b0000, 16'h0, 16'h0, 4'b0001, 16'h0002, 64'hBEEF, 4'b0000, 4'b0001, 1'b1, 16'h005A, 16'h0077);
        tbl[10] = mk(4'b0010, 16'h0020, 16'h0020, 4'b0000, 16'h0, 64'h0, 4'b0010, 4'b0000, 1'b0, 16'hBEEF, 16'hBEEF);

        repeat (3) @(posedge clk);
        #1;
        chk("reset rsp_valid", 64'(rsp_v), 64'h0);
        chk("reset data1", 64'(d1), 64'h0);
        chk("reset oob", 64'(oob), 64'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("idle rd_rdy", 64'(rd_rdy), 64'h0);
            chk("idle wr_rdy", 64'(wr_rdy), 64'h0);
            chk("idle wen", 64'(rf_wen), 64'h0);
            tick();
            chk("idle rsp_valid", 64'(rsp_v), 64'h0);
            chk("idle oob", 64'(oob), 64'h0);
        end

        preload(4'd3, 16'h00A5);
        preload(4'd7, 16'h005A);
        preload(4'd6, 16'h0077);

        idle();
        set_rd(2, 4'd3, 4'd7);
        #1;
        chk("single rd_rdy", 64'(rd_rdy), 64'h4);
        tick();
        chk("single rsp_valid", 64'(rsp_v), 64'h4);
        chk("single data1", 64'(d1), 64'hA5);
        chk("single data2", 64'(d2), 64'h5A);
        idle();
        tick();
        chk("single rsp one-shot", 64'(rsp_v), 64'h0);
        chk("single data hold", 64'(d1), 64'hA5);

        for (int j = 0; j < 4; j++) cnt[j] = 0;
        for (int k = 0; k < 11; k++) begin
            rd_v = tbl[k].rv; rd_a1 = tbl[k].a1; rd_a2 = tbl[k].a2;
            wr_v = tbl[k].wv; wr_a = tbl[k].wa; wr_d = tbl[k].wd;
            #1;
            chk($sformatf("row%0d rd_rdy", k), 64'(rd_rdy), 64'(tbl[k].e_rrdy));
            chk($sformatf("row%0d wr_rdy", k), 64'(wr_rdy), 64'(tbl[k].e_wrdy));
            chk($sformatf("row%0d wen", k), 64'(rf_wen), 64'(tbl[k].e_wen));
            tick();
            chk($sformatf("row%0d rsp_valid", k), 64'(rsp_v), 64'(tbl[k].e_rrdy));
            chk($sformatf("row%0d data1", k), 64'(d1), 64'(tbl[k].e_d1));
            chk($sformatf("row%0d data2", k), 64'(d2), 64'(tbl[k].e_d2));
            if (k >= 1 && k <= 8)
                for (int j = 0; j < 4; j++) cnt[j] += int'(rsp_v[j]);
        end
        for (int j = 0; j < 4; j++) chk($sformatf("rr responses req%0d", j), 64'(cnt[j]), 64'd2);

        idle();
        set_wr(0, 4'd5, 16'h1234);
        set_rd(1, 4'd5, 4'd6);
        #1;
        chk("bypass rd_rdy", 64'(rd_rdy), 64'h2);
        chk("bypass wr_rdy", 64'(wr_rdy), 64'h1);
        chk("bypass wen", 64'(rf_wen), 64'h1);
        chk("bypass rf_rd_addr1", 64'(rf_ra1), 64'h5);
        chk("bypass rf_wr_addr", 64'(rf_wa), 64'h5);
        tick();
        chk("bypass rsp_valid", 64'(rsp_v), 64'h2);
        chk("bypass data1", 64'(d1), 64'h1234);
        chk("bypass data2", 64'(d2), 64'h77);
        idle();
        set_rd(1, 4'd5, 4'd5);
        tick();
        chk("reread data1", 64'(d1), 64'h1234);
        chk("reread data2", 64'(d2), 64'h1234);
        idle();
        set_wr(2, 4'd9, 16'h4321);
        set_rd(2, 4'd9, 4'd9);
        #1;
        chk("dual rd_rdy", 64'(rd_rdy), 64'h4);
        chk("dual wr_rdy", 64'(wr_rdy), 64'h4);
        tick();
        chk("dual bypass data1", 64'(d1), 64'h4321);
        chk("dual bypass data2", 64'(d2), 64'h4321);
        idle();
        #1;
        chk("no grant rf_rd_addr1", 64'(rf_ra1), 64'h0);
        tick();
        chk("no grant rsp_valid", 64'(rsp_v), 64'h0);
        chk("no grant data hold", 64'(d2), 64'h4321);

        set_wr(1, 4'd12, 16'hDEAD);
        #1;
        chk("oob wr_rdy", 64'(wr_rdy), 64'h2);
        chk("oob wen", 64'(rf_wen), 64'h0);
        tick();
        chk("oob set", 64'(oob), 64'h1);
        idle();
        tick();
        chk("oob sticky", 64'(oob), 64'h1);
        set_rd(0, 4'd12, 4'd3);
        #1;
        chk("oob rd_rdy", 64'(rd_rdy), 64'h1);
        tick();
        chk("oob rd rsp_valid", 64'(rsp_v), 64'h1);
        chk("oob rd data1", 64'(d1), 64'h0);
        chk("oob rd data2", 64'(d2), 64'hA5);
        chk("oob still set", 64'(oob), 64'h1);

        idle();
        set_rd(2, 4'd3, 4'd7);
        #1;
        chk("pre-reset rd_rdy", 64'(rd_rdy), 64'h4);
        tick();
        chk("pre-reset rsp_valid", 64'(rsp_v), 64'h4);
        rst_n = 1'b0;
        idle();
        set_rd(1, 4'd3, 4'd3);
        set_rd(3, 4'd7, 4'd7);
        set_wr(1, 4'd4, 16'h0055);
        set_wr(3, 4'd4, 16'h0066);
        #1;
        chk("async rsp_valid", 64'(rsp_v), 64'h0);
        chk("in reset rd_rdy", 64'(rd_rdy), 64'h0);
        chk("in reset wr_rdy", 64'(wr_rdy), 64'h0);
        chk("in reset wen", 64'(rf_wen), 64'h0);
        chk("in reset oob", 64'(oob), 64'h0);
        tick();
        chk("in reset rsp_valid", 64'(rsp_v), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("post-reset rd_rdy", 64'(rd_rdy), 64'h2);
        chk("post-reset wr_rdy", 64'(wr_rdy), 64'h2);
        tick();
        chk("post-reset rsp_valid", 64'(rsp_v), 64'h2);
        chk("post-reset data1", 64'(d1), 64'hA5);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
